// File: rtl/bounce_decoder_if.sv
// Pattern-word bus for the bounce decoder: the producer drives vld/pat, the
// decoder returns the decoded position, direction, lock state and event counters.
interface bounce_decoder_if #(
  parameter int unsigned N             = 8,
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned PW            = $clog2(N)
) ();

  logic                     vld;
  logic [N-1:0]             pat;
  logic [PW-1:0]            pos;
  logic                     dir;
  logic                     locked;
  logic                     tc_det;
  logic                     err_onehot;
  logic                     err_step;
  logic [COUNTER_WIDTH-1:0] period_count;
  logic [COUNTER_WIDTH-1:0] err_count;

  modport master (
    output vld, pat,
    input  pos, dir, locked, tc_det, err_onehot, err_step, period_count, err_count
  );

  modport slave (
    input  vld, pat,
    output pos, dir, locked, tc_det, err_onehot, err_step, period_count, err_count
  );

endinterface

// File: rtl/bounce_decoder.sv
// Bounce decoder: tracks a single set bit sweeping back and forth across an
// N-bit word (N-1 down to 0 and back), flags illegal words and counts periods.
module bounce_decoder #(
  parameter int unsigned N             = 8,
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned PW            = $clog2(N)
) (
  input logic              clk,
  input logic              rstna,
  bounce_decoder_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  localparam logic [N-1:0]  PatOne = N'(1);
  localparam logic [PW-1:0] PosMax = PW'(N - 1);

  state_e                   state_q;
  logic [PW-1:0]            pos_q;
  logic                     dir_q;
  logic                     locked_q;
  logic                     tc_q;
  logic                     err_onehot_q;
  logic                     err_step_q;
  logic [COUNTER_WIDTH-1:0] period_q;
  logic [COUNTER_WIDTH-1:0] err_cnt_q;

  logic                     onehot;
  logic [PW-1:0]            new_pos;
  logic [PW:0]              new_ext;
  logic [PW:0]              pos_up;
  logic [PW:0]              pos_dn;
  logic                     adjacent;
  logic                     on_track;
  logic [COUNTER_WIDTH-1:0] err_cnt_inc;

  // Decode the incoming word and precompute neighbour positions. Positions are
  // compared one bit wider so that pos-1 at position 0 can never match a word.
  always_comb begin
    onehot  = (bus.pat != '0) && ((bus.pat & (bus.pat - PatOne)) == '0);
    new_pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.pat[i]) new_pos = PW'(i);
    end
    new_ext     = {1'b0, new_pos};
    pos_up      = {1'b0, pos_q} + 1'b1;
    pos_dn      = {1'b0, pos_q} - 1'b1;
    adjacent    = (new_ext == pos_up) || (new_ext == pos_dn);
    on_track    = (new_ext == (dir_q ? pos_dn : pos_up));
    err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + COUNTER_WIDTH'(1);
  end

  // Sequence FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      state_q      <= StIdle;
      pos_q        <= '0;
      dir_q        <= 1'b1;
      locked_q     <= 1'b0;
      tc_q         <= 1'b0;
      err_onehot_q <= 1'b0;
      err_step_q   <= 1'b0;
      period_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      tc_q         <= 1'b0;
      err_onehot_q <= 1'b0;
      err_step_q   <= 1'b0;
      if (bus.vld) begin
        if (!onehot) begin
          // Malformed word wins over any sequence error; position is kept.
          err_onehot_q <= 1'b1;
          err_cnt_q    <= err_cnt_inc;
          locked_q     <= 1'b0;
          state_q      <= StIdle;
        end else begin
          unique case (state_q)
            StIdle: begin
              pos_q    <= new_pos;
              locked_q <= 1'b0;
              state_q  <= StAcquire;
            end
            StAcquire: begin
              pos_q <= new_pos;
              if (adjacent) begin
                dir_q    <= (new_pos < pos_q);
                locked_q <= 1'b1;
                state_q  <= StLocked;
              end
            end
            StLocked: begin
              pos_q <= new_pos;
              if (on_track) begin
                if (new_pos == '0) begin
                  dir_q    <= 1'b0;
                  tc_q     <= 1'b1;
                  period_q <= period_q + COUNTER_WIDTH'(1);
                end else if (new_pos == PosMax) begin
                  dir_q <= 1'b1;
                end
              end else begin
                err_step_q <= 1'b1;
                err_cnt_q  <= err_cnt_inc;
                locked_q   <= 1'b0;
                state_q    <= StAcquire;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign bus.pos          = pos_q;
  assign bus.dir          = dir_q;
  assign bus.locked       = locked_q;
  assign bus.tc_det       = tc_q;
  assign bus.err_onehot   = err_onehot_q;
  assign bus.err_step     = err_step_q;
  assign bus.period_count = period_q;
  assign bus.err_count    = err_cnt_q;

endmodule

// File: tb/tb_bounce_decoder.sv
// Self-checking bench for bounce_decoder: a table of words with expected
// outputs fed through a scoreboard queue, plus hand-written corner sequences
// and a narrow-counter instance for saturation and wrap.
module tb_bounce_decoder;

  typedef struct packed {
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       tc;
    logic       eoh;
    logic       est;
    logic [7:0] pc;
    logic [7:0] ec;
  } out_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] pat;
    out_t       exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rstna = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vec_t vecs[$];
  out_t sb_q[$];

  always #5 clk = ~clk;

  bounce_decoder_if #(.N(8), .COUNTER_WIDTH(8)) bus ();
  bounce_decoder_if #(.N(8), .COUNTER_WIDTH(2)) bus2 ();

  bounce_decoder #(.N(8), .COUNTER_WIDTH(8)) dut (
    .clk   (clk),
    .rstna (rstna),
    .bus   (bus)
  );

  bounce_decoder #(.N(8), .COUNTER_WIDTH(2)) dut2 (
    .clk   (clk),
    .rstna (rstna),
    .bus   (bus2)
  );

  function automatic out_t o(int p, bit d, bit l, bit t, bit eo, bit es, int pc, int ec);
    out_t r;
    r.pos = 3'(p); r.dir = d; r.locked = l; r.tc = t; r.eoh = eo; r.est = es;
    r.pc = 8'(pc); r.ec = 8'(ec);
    return r;
  endfunction

  function automatic vec_t v(bit vl, logic [7:0] p, out_t e);
    vec_t r;
    r.vld = vl; r.pat = p; r.exp = e;
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r.pos = bus.pos; r.dir = bus.dir; r.locked = bus.locked; r.tc = bus.tc_det;
    r.eoh = bus.err_onehot; r.est = bus.err_step;
    r.pc = bus.period_count; r.ec = bus.err_count;
    return r;
  endfunction

  task automatic cmp_out(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pos=%0d dir=%0b lk=%0b tc=%0b eoh=%0b est=%0b pc=%0d ec=%0d, want pos=%0d dir=%0b lk=%0b tc=%0b eoh=%0b est=%0b pc=%0d ec=%0d",
               name, act.pos, act.dir, act.locked, act.tc, act.eoh, act.est, act.pc, act.ec,
               exp.pos, exp.dir, exp.locked, exp.tc, exp.eoh, exp.est, exp.pc, exp.ec);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one word, queue its expectation, and compare once the edge has passed.
  task automatic apply(input string name, input logic vl, input logic [7:0] p, input out_t e);
    out_t exp;
    bus.vld = vl;
    bus.pat = p;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    cmp_out(name, sample(), exp);
  endtask

  task automatic step2(input logic [7:0] p);
    bus2.vld = 1'b1;
    bus2.pat = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.vld  = 1'b0;
    bus.pat  = '0;
    bus2.vld = 1'b0;
    bus2.pat = '0;

    // Locking, full sweep, step error and recovery.
    vecs.push_back(v(1, 8'h80, o(7, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h40, o(6, 1, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h20, o(5, 1, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h10, o(4, 1, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h08, o(3, 1, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h04, o(2, 1, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h02, o(1, 1, 1, 0, 0, 0, 0, 0)));
    vecs.push_back(v(1, 8'h01, o(0, 0, 1, 1, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h02, o(1, 0, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h04, o(2, 0, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h08, o(3, 0, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h10, o(4, 0, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h20, o(5, 0, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h40, o(6, 0, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h80, o(7, 1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h40, o(6, 1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h20, o(5, 1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h10, o(4, 1, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(v(1, 8'h04, o(2, 1, 0, 0, 0, 1, 1, 1)));
    vecs.push_back(v(1, 8'h02, o(1, 1, 1, 0, 0, 0, 1, 1)));
    // Resume after the idle gap, then malformed words and reacquisition.
    vecs.push_back(v(1, 8'h01, o(0, 0, 1, 1, 0, 0, 2, 1)));
    vecs.push_back(v(1, 8'h00, o(0, 0, 0, 0, 1, 0, 2, 2)));
    vecs.push_back(v(1, 8'h18, o(0, 0, 0, 0, 1, 0, 2, 3)));
    vecs.push_back(v(1, 8'h08, o(3, 0, 0, 0, 0, 0, 2, 3)));
    vecs.push_back(v(1, 8'h08, o(3, 0, 0, 0, 0, 0, 2, 3)));
    vecs.push_back(v(1, 8'h20, o(5, 0, 0, 0, 0, 0, 2, 3)));
    vecs.push_back(v(1, 8'h10, o(4, 1, 1, 0, 0, 0, 2, 3)));

    // Asynchronous reset with no clock edge in between.
    #2 rstna = 1'b0;
    #1;
    cmp_out("reset_async", sample(), o(0, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk) rstna = 1'b1;

    for (int i = 0; i < 20; i++) apply($sformatf("vec[%0d]", i), vecs[i].vld, vecs[i].pat,
                                       vecs[i].exp);

    // vld low with garbage on pat: everything holds, no pulses.
    for (int i = 0; i < 10; i++) apply($sformatf("hold[%0d]", i), 1'b0, 8'($urandom),
                                       o(1, 1, 1, 0, 0, 0, 1, 1));

    for (int i = 20; i < vecs.size(); i++) apply($sformatf("vec[%0d]", i), vecs[i].vld,
                                                  vecs[i].pat, vecs[i].exp);

    // Reset mid-sequence: history discarded, two legal words needed to relock.
    rstna = 1'b0;
    #1;
    cmp_out("reset_mid", sample(), o(0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rstna = 1'b1;
    apply("relock_1", 1'b1, 8'h08, o(3, 1, 0, 0, 0, 0, 0, 0));
    apply("relock_2", 1'b1, 8'h04, o(2, 1, 1, 0, 0, 0, 0, 0));
    bus.vld = 1'b0;

    // Narrow counters: error count saturates, period count wraps.
    rstna = 1'b0;
    @(negedge clk) rstna = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step2(8'h00);
      chk($sformatf("sat_err[%0d]", i), 32'(bus2.err_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk($sformatf("sat_eoh[%0d]", i), 32'(bus2.err_onehot), 32'd1);
    end
    step2(8'h80);
    step2(8'h40);
    for (int s = 0; s < 5; s++) begin
      for (int p = 5; p >= 0; p--) begin
        step2(8'h01 << p);
        if (p == 0) begin
          chk($sformatf("wrap_tc[%0d]", s), 32'(bus2.tc_det), 32'd1);
          chk($sformatf("wrap_pc[%0d]", s), 32'(bus2.period_count), 32'((s + 1) % 4));
        end
      end
      for (int p = 1; p <= 7; p++) step2(8'h01 << p);
      step2(8'h40);
    end
    chk("wrap_err_hold", 32'(bus2.err_count), 32'd3);
    chk("wrap_locked", 32'(bus2.locked), 32'd1);
    chk("wrap_pos", 32'(bus2.pos), 32'd6);
    chk("wrap_dir", 32'(bus2.dir), 32'd1);
    bus2.vld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bounce_decoder.md
BOUNCE_DECODER -- requirements
Module: bounce_decoder

Interface
REQ-001 Parameter N, default 8, meaning width of the observed one-hot pattern word; N SHALL be >= 3.
REQ-002 Parameter COUNTER_WIDTH, default 8, meaning width of the period and error counters.
REQ-003 Parameter PW, default $clog2(N), meaning width of the decoded position.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstna  input  1  reset, asynchronous assertion, active-low.
REQ-006 vld  input  1  a new pattern word is present on pat this cycle.
REQ-007 pat  input  N  observed pattern word; bit 0 is the LSB end of the sweep.
REQ-008 pos  output  PW  binary index of the set bit in the last accepted word.
REQ-009 dir  output  1  1 = moving toward LSB (right); 0 = moving toward MSB (left).
REQ-010 locked  output  1  decoder is tracking a legal bounce sequence.
REQ-011 tc_det  output  1  one-cycle pulse when position 0 is reached while locked.
REQ-012 err_onehot  output  1  one-cycle pulse when pat is not exactly one-hot.
REQ-013 err_step  output  1  one-cycle pulse when a one-hot word breaks the expected sequence.
REQ-014 period_count  output  COUNTER_WIDTH  number of tc_det events, wraps modulo 2^COUNTER_WIDTH.
REQ-015 err_count  output  COUNTER_WIDTH  total err_onehot plus err_step events, saturating at all-ones.

Function
REQ-016 The block SHALL sample pat only on cycles with vld=1; with vld=0, all state and level outputs SHALL hold and all pulse outputs SHALL be 0.
REQ-017 All outputs SHALL be registered; the response to a word accepted at edge k SHALL be visible after edge k.
REQ-018 The FSM SHALL have exactly three states: IDLE (no history), ACQUIRE (one valid position stored), LOCKED.
REQ-019 In any state, a non-one-hot pat (zero or two or more bits set) SHALL pulse err_onehot, increment err_count, clear locked, and move to IDLE; pos and dir SHALL hold.
REQ-020 IDLE + one-hot pat -> store pos, move to ACQUIRE, locked stays 0.
REQ-021 ACQUIRE + one-hot pat at distance exactly 1 from stored pos -> update pos, set dir=1 if the new pos is lower else 0, move to LOCKED, locked=1.
REQ-022 ACQUIRE + one-hot pat at any other distance (including 0) -> store the new pos, stay in ACQUIRE, no error pulse.
REQ-023 In LOCKED, the expected next position SHALL be pos-1 when dir=1 and pos+1 when dir=0.
REQ-024 In LOCKED, on acceptance of new pos 0, dir SHALL become 0; on new pos N-1, dir SHALL become 1; otherwise dir SHALL follow the move direction.
REQ-025 In LOCKED, a one-hot word matching the expected position SHALL update pos; if the new pos is 0, tc_det SHALL pulse and period_count SHALL increment.
REQ-026 In LOCKED, a one-hot word not matching the expected position SHALL pulse err_step, increment err_count, store the new pos, clear locked, and move to ACQUIRE.
REQ-027 A word that is both non-one-hot and out of sequence SHALL raise err_onehot only; err_onehot and err_step SHALL never both be 1.
REQ-028 err_count SHALL not wrap: at all-ones it SHALL remain all-ones on further errors.
REQ-029 The legal locked sequence for N=8 starting at 7 SHALL be 7,6,5,4,3,2,1,0,1,2,...,7,6,... (period 2N-2 words).

Reset
REQ-030 With rstna=0, asynchronously and regardless of clk: state=IDLE, pos=0, dir=1, locked=0, tc_det=0, err_onehot=0, err_step=0, period_count=0, err_count=0.
REQ-031 Reset asserted mid-sequence SHALL discard all history; after release, two legal consecutive words SHALL be required before locked=1.
REQ-032 Reset deassertion SHALL take effect synchronously; the first word accepted is the one sampled at the first rising edge with rstna=1.

Verification
REQ-033 Reset, then vld=1 with words 0x80,0x40,0x20 -> locked=1 after 2nd word, pos=6 then 5, dir=1, no error pulses.
REQ-034 Full sweep 0x80 down to 0x01 and back to 0x80 -> tc_det exactly once (when pos=0), period_count=1, dir=0 after 0x01 and dir=1 after 0x80.
REQ-035 Locked at pos=4 dir=1, inject 0x04 -> err_step pulse, err_count=1, locked=0, pos=2; then 0x02 -> locked=1, dir=1.
REQ-036 Inject 0x00 then 0x18 -> err_onehot pulses twice, err_step never, err_count=2, state IDLE, pos unchanged.
REQ-037 Locked, vld held 0 for 10 cycles with pat changing arbitrarily -> no pulses, pos/dir/counters unchanged; resuming with the expected word continues without error.
REQ-038 COUNTER_WIDTH=2, inject 5 non-one-hot words -> err_count=3 and stays 3; 5 sweeps -> period_count wraps to 1.
